// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter owning the select of one shared WIDTH-bit bus net.
// Grants are held up to MAX_HOLD cycles while others wait; the owner's lock
// bit extends a grant indefinitely for atomic multi-cycle transfers.
module shared_bus_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           bus_data,
  output logic                       handover
);

  localparam int unsigned OW = $clog2(N_REQ);
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             handover_q, handover_d;

  logic [OW-1:0]    ptr_inc;
  logic [N_REQ-1:0] others;
  logic [OW-1:0]    sel_idle;
  logic [OW-1:0]    sel_rel;
  logic             rel;

  // First requester at or after start, wrapping modulo N_REQ.
  function automatic logic [OW-1:0] pick(input logic [N_REQ-1:0] r,
                                         input logic [OW-1:0]    start);
    logic [OW-1:0] res;
    logic          found;
    int unsigned   idx;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(start) + k) % N_REQ;
      if (!found && r[idx]) begin
        res   = OW'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign ptr_inc  = OW'((32'(owner_q) + 32'd1) % N_REQ);
  assign others   = req & ~gnt_q;
  assign sel_idle = pick(req, ptr_q);
  assign sel_rel  = pick(req, ptr_inc);
  assign rel      = !req[owner_q] ||
                    (!lock[owner_q] && (hold_q == HW'(MAX_HOLD)) && (|others));

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      handover_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      handover_q <= handover_d;
    end
  end

  // Next-state: grant from idle, release/preempt with zero-bubble regrant, or hold.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    handover_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = ONE << sel_idle;
          owner_d = sel_idle;
          busy_d  = 1'b1;
          hold_d  = HW'(1);
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (rel) begin
          ptr_d = ptr_inc;
          if (|others) begin
            gnt_d      = ONE << sel_rel;
            owner_d    = sel_rel;
            hold_d     = HW'(1);
            handover_d = 1'b1;
          end else begin
            gnt_d   = '0;
            busy_d  = 1'b0;
            hold_d  = '0;
            state_d = IDLE;
          end
        end else if (hold_q != HW'(MAX_HOLD)) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Shared net: only the owner's slice ever reaches the bus.
  always_comb begin
    bus_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (busy_q && (owner_q == OW'(i))) bus_data = wdata[i*WIDTH +: WIDTH];
    end
  end

  assign gnt      = gnt_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign handover = handover_q;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Directed bench for shared_bus_arbiter (N_REQ=4, WIDTH=16, MAX_HOLD=8).
module tb_shared_bus_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [63:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic        busy;
  logic [15:0] bus_data;
  logic        handover;

  int total;
  int bad;

  logic [15:0] wd [4];

  shared_bus_arbiter #(.N_REQ(4), .WIDTH(16), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .wdata(wdata),
    .gnt(gnt), .owner(owner), .busy(busy), .bus_data(bus_data),
    .handover(handover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    lock = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; lock = '0;
    #3;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL reset_handover got=%b exp=0", handover); end
    total++; if (bus_data !== 16'h0) begin bad++; $display("FAIL reset_bus got=%h exp=0000", bus_data); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++; if (bus_data !== 16'habcd) begin bad++; $display("FAIL single_bus got=%h exp=abcd", bus_data); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL single_ho got=%b exp=0", handover); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL single_drop_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_drop_busy got=%b exp=0", busy); end
    total++; if (bus_data !== 16'h0) begin bad++; $display("FAIL single_drop_bus got=%h exp=0000", bus_data); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL single_drop_ho got=%b exp=0", handover); end
  endtask

  task automatic test_rotate();
    logic [3:0] eg;
    logic       eh;
    do_reset();
    req = 4'b1111;
    tick();
    for (int o = 0; o < 5; o++) begin
      eg = 4'b0001 << (o % 4);
      for (int c = 0; c < 8; c++) begin
        eh = (c == 0) && (o != 0);
        total++; if (gnt !== eg) begin bad++; $display("FAIL rot_gnt o=%0d c=%0d got=%b exp=%b", o, c, gnt, eg); end
        total++; if (handover !== eh) begin bad++; $display("FAIL rot_ho o=%0d c=%0d got=%b exp=%b", o, c, handover, eh); end
        total++; if (bus_data !== wd[o % 4]) begin bad++; $display("FAIL rot_bus o=%0d c=%0d got=%h exp=%h", o, c, bus_data, wd[o % 4]); end
        tick();
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL lock_first got=%b exp=0100", gnt); end
    req  = 4'b0101;
    lock = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL lock_hold c=%0d got=%b exp=0100", c, gnt); end
    end
    lock = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL lock_preempt got=%b exp=0001", gnt); end
    total++; if (handover !== 1'b1) begin bad++; $display("FAIL lock_preempt_ho got=%b exp=1", handover); end
    total++; if (owner !== 2'd0) begin bad++; $display("FAIL lock_preempt_owner got=%0d exp=0", owner); end
  endtask

  task automatic test_solo();
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 30; c++) begin
      tick();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL solo_gnt c=%0d got=%b exp=0100", c, gnt); end
      total++; if (handover !== 1'b0) begin bad++; $display("FAIL solo_ho c=%0d got=%b exp=0", c, handover); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL b2b_gnt3 got=%b exp=1000", gnt); end
    total++; if (handover !== 1'b1) begin bad++; $display("FAIL b2b_ho3 got=%b exp=1", handover); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    req = 4'b1101;
    tick();
    req = 4'b0101;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL b2b_gnt0 got=%b exp=0001", gnt); end
    total++; if (handover !== 1'b1) begin bad++; $display("FAIL b2b_ho0 got=%b exp=1", handover); end
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL b2b_gnt2 got=%b exp=0100", gnt); end
    total++; if (bus_data !== wd[2]) begin bad++; $display("FAIL b2b_bus2 got=%h exp=%h", bus_data, wd[2]); end
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL b2b_idle got=%b exp=0000", gnt); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL b2b_idle_ho got=%b exp=0", handover); end
    // Owner 1 hands over to the pointer-selected requester 2 ahead of 3.
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL b2b_ptr2 got=%b exp=0100", gnt); end
    // Single requester re-grant goes through idle without a pulse.
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL b2b_regrant got=%b exp=0100", gnt); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL b2b_regrant_ho got=%b exp=0", handover); end
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL ar_pre got=%b exp=1000", gnt); end
    #3;
    rst = 1'b1;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL ar_gnt got=%b exp=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ar_busy got=%b exp=0", busy); end
    total++; if (bus_data !== 16'h0) begin bad++; $display("FAIL ar_bus got=%h exp=0000", bus_data); end
    req = 4'b1010;
    tick();
    rst = 1'b0;
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL ar_regrant got=%b exp=0010", gnt); end
    total++; if (owner !== 2'd1) begin bad++; $display("FAIL ar_owner got=%0d exp=1", owner); end
    total++; if (handover !== 1'b0) begin bad++; $display("FAIL ar_ho got=%b exp=0", handover); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    wd[0] = 16'habcd; wd[1] = 16'h2222; wd[2] = 16'h3333; wd[3] = 16'h4444;
    wdata = {wd[3], wd[2], wd[1], wd[0]};
    rst   = 1'b1;
    req   = '0;
    lock  = '0;
    test_reset();
    test_single();
    test_rotate();
    test_lock();
    test_solo();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
